sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO. Next generation of the fixed depth-4 FIFO:
//   configurable WIDTH/DEPTH, occupancy count, almost-full/almost-empty thresholds.
//   Sticky overflow/underflow error flags; defined behaviour when full or empty.
//   Sits between producer/consumer stages, e.g. host-to-accelerator word streams
//   and memory read-return buffering.
// PARAMETERS
//   WIDTH          32        data word width in bits (>=1)
//   DEPTH          16        number of entries; power of 2, >=2
//   AFULL_THRESH   DEPTH-2   almost_full asserted when count >= AFULL_THRESH
//   AEMPTY_THRESH  2         almost_empty asserted when count <= AEMPTY_THRESH
// PORTS
//   clock         in   1                 rising-edge clock
//   reset         in   1                 async active-high reset
//   data_in       in   WIDTH             write data
//   we            in   1                 write request
//   re            in   1                 read/pop request
//   clear_err     in   1                 sync clear of overflow/underflow
//   data_out      out  WIDTH             head word (first-word-fall-through)
//   full          out  1                 count == DEPTH
//   empty         out  1                 count == 0
//   almost_full   out  1                 count >= AFULL_THRESH
//   almost_empty  out  1                 count <= AEMPTY_THRESH
//   count         out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//   overflow      out  1                 sticky: write refused while full
//   underflow     out  1                 sticky: read refused while empty
// BEHAVIOUR
// - Reset (async, any time, incl. mid-burst): wr_ptr=rd_ptr=0, count=0.
//   Reset also clears overflow=underflow=0. Storage array is not reset.
//   Reset outputs: empty=1, full=0, almost_empty=1, data_out='0.
//   almost_full=0 unless AFULL_THRESH==0.
// - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is held separately.
// - data_out is combinational: mem[rd_ptr] when !empty, else '0 (never 'z).
// - Write latency: a word written at edge N is on data_out after edge N when the
//   FIFO was empty. Pop takes effect on the clock edge; the next word appears
//   after that edge.
// - Accepted write: we && (!full || (re && !empty)).
//   Stores mem[wr_ptr]<=data_in and increments wr_ptr.
// - Accepted read: re && !empty. Increments rd_ptr.
// - Simultaneous we&re:
//   - not empty, not full: both accepted; count unchanged.
//   - full: both accepted; the pop frees the slot; count stays DEPTH, no overflow.
//   - empty: write only; count 0->1; underflow set; data_out=data_in after edge.
// - we && full && !re: write dropped; contents and pointers unchanged; overflow<=1.
// - re && empty: no pointer change; underflow<=1.
// - clear_err: overflow/underflow<=0 next edge. If an error event occurs in the
//   same cycle, set wins.
// - count width arithmetic: +1 / -1 / 0 only; saturation is impossible by rules above.
// - Flags derive combinationally from count (no extra latency).
// TESTING
// - DEPTH=16, WIDTH=32: write 0..15 -> full=1, count=16, almost_full from count=14.
//   17th write -> overflow=1. Then read 16 -> data 0..15 in order, empty=1.
// - Empty FIFO: we=1 with data 0xA5 and re=1 same cycle -> count=1, underflow=1,
//   data_out=0xA5 next cycle. clear_err -> underflow=0.
// - Full FIFO: we&re for 8 cycles with data 100..107 -> count stays 16, overflow=0.
//   Drain yields 8..15 then 100..107.
// - Wrap: stream 40 words with count oscillating 0..5 -> output order is exactly
//   0..39, pointers wrap twice, no flags.
// - Reset mid-op: count=9, assert reset between edges -> immediately count=0,
//   empty=1, data_out=0. After release, write 0x3C -> data_out=0x3C.
// - clear_err with same-cycle overflow write -> overflow remains 1.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with first-word-fall-through output, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   we,
    input  logic                   re,
    input  logic                   clear_err,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfullCnt  = CntW'(AFULL_THRESH);
    localparam logic [CntW-1:0] AemptyCnt = CntW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;

    logic wr_accept;
    logic rd_accept;

    assign full         = (count_q == DepthCnt);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfullCnt);
    assign almost_empty = (count_q <= AemptyCnt);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Storage slots are never read while empty, so data_out is forced to zero there.
    assign data_out = empty ? '0 : mem[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign rd_accept = re && !empty;
    assign wr_accept = we && (!full || rd_accept);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Clear first so a same-cycle error event overrides it.
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (we && full && !re) begin
            overflow_d = 1'b1;
        end
        if (re && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param: a queue-based reference model feeds a
// scoreboard that a mid-cycle monitor checks against the DUT outputs.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             we = 1'b0;
    logic             re = 1'b0;
    logic             clear_err = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             overflow;
    logic             underflow;

    sync_fifo_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .we          (we),
        .re          (re),
        .clear_err   (clear_err),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    // Reference model: words the FIFO should hold, plus occupancy and sticky error bits.
    logic [WIDTH-1:0] exp_q[$];
    int  m_cnt = 0;
    bit  m_ovf = 1'b0;
    bit  m_udf = 1'b0;
    // Model state that the DUT should currently be showing.
    int  cur_cnt = 0;
    bit  cur_ovf = 1'b0;
    bit  cur_udf = 1'b0;
    bit  run = 1'b0;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit c);
        bit rd_ok;
        bit wr_ok;
        @(posedge clock);
        #1;
        cur_cnt   = m_cnt;
        cur_ovf   = m_ovf;
        cur_udf   = m_udf;
        we        = w;
        re        = r;
        data_in   = d;
        clear_err = c;
        rd_ok = r && (m_cnt > 0);
        wr_ok = w && ((m_cnt < int'(DEPTH)) || rd_ok);
        if (wr_ok) exp_q.push_back(d);
        if (c) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (w && !wr_ok) m_ovf = 1'b1;
        if (r && !rd_ok) m_udf = 1'b1;
        m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    endtask

    // Monitor: checks flags every cycle and consumes a scoreboard entry on each pop.
    initial begin
        forever begin
            @(negedge clock);
            if (run && !reset) begin
                chk("count", 64'(count), 64'(cur_cnt));
                chk("full", 64'(full), 64'(cur_cnt == int'(DEPTH)));
                chk("empty", 64'(empty), 64'(cur_cnt == 0));
                chk("almost_full", 64'(almost_full), 64'(cur_cnt >= int'(DEPTH) - 2));
                chk("almost_empty", 64'(almost_empty), 64'(cur_cnt <= 2));
                chk("overflow", 64'(overflow), 64'(cur_ovf));
                chk("underflow", 64'(underflow), 64'(cur_udf));
                if (cur_cnt == 0) begin
                    chk("data_out_when_empty", 64'(data_out), 64'd0);
                end else if (exp_q.size() > 0) begin
                    chk("data_out_head", 64'(data_out), 64'(exp_q[0]));
                end
                if (re && !empty) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL pop_without_data at %0t: got data %0h expected no pop",
                                 $time, data_out);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic fill(input int n, input int base);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, WIDTH'(base + i), 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_almost_full", 64'(almost_full), 64'd0);
        chk("reset_almost_empty", 64'(almost_empty), 64'd1);
        chk("reset_data_out", 64'(data_out), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_underflow", 64'(underflow), 64'd0);
        reset = 1'b0;
        run   = 1'b1;

        // Fill to full, one refused write, then drain in order.
        fill(16, 0);
        cycle(1'b1, 1'b0, 32'd99, 1'b0);
        drain(16);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Simultaneous write and read on an empty FIFO.
        cycle(1'b1, 1'b1, 32'hA5, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        drain(1);

        // Write and read together while full.
        fill(16, 0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, WIDTH'(100 + i), 1'b0);
        drain(16);

        // Pointer wrap with occupancy oscillating 0..5.
        for (int b = 0; b < 8; b++) begin
            fill(5, b * 5);
            drain(5);
        end

        // clear_err coinciding with a refused write: overflow must stay set.
        fill(16, 300);
        cycle(1'b1, 1'b0, 32'd77, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0);
        drain(16);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Randomised traffic alternating write-heavy and read-heavy phases.
        for (int i = 0; i < 400; i++) begin
            bit wh;
            bit w;
            bit r;
            bit c;
            wh = ((i / 50) % 2) == 0;
            w  = wh ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r  = wh ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 19) == 0);
            cycle(w, r, WIDTH'($urandom), c);
        end

        // Asynchronous reset in the middle of a cycle with 9 words held.
        while (m_cnt > 0) cycle(1'b0, 1'b1, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        fill(9, 'h200);
        @(posedge clock);
        #1;
        chk("pre_reset_count", 64'(count), 64'd9);
        we        = 1'b0;
        re        = 1'b0;
        clear_err = 1'b0;
        reset     = 1'b1;
        #1;
        chk("mid_reset_count", 64'(count), 64'd0);
        chk("mid_reset_empty", 64'(empty), 64'd1);
        chk("mid_reset_data_out", 64'(data_out), 64'd0);
        exp_q.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        cur_cnt = 0;
        cur_ovf = 1'b0;
        cur_udf = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(1'b1, 1'b0, 32'h3C, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        @(negedge clock);
        #1;
        chk("post_reset_data_out", 64'(data_out), 64'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
